// File: rtl/rv_decode_execute_if.sv
// Bus between the decode/execute core and its neighbours (fetch, register
// file, control generator, data memory).
//   master : the surrounding datapath. Drives instrucao, the operands and
//            the control bits, and observes the core's state, decode fields
//            and ALU results.
//   slave  : rv_decode_execute itself.
// There is no valid/ready handshake on this bus. Every consumer paces itself
// off estado. An input is sampled only in the state that uses it:
// instrucao in ID, and the operands and control bits in EX.
interface rv_decode_execute_if #(
  parameter int XLEN = 32
);
  logic [31:0]     instrucao;
  logic [XLEN-1:0] readdata1R;
  logic [XLEN-1:0] readdata2R;
  logic            alusrc;
  logic [3:0]      alucontrol;
  logic            branch;

  logic [3:0]      estado;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [11:0]     immediate;
  logic [2:0]      tipo;
  logic            aluresult1;
  logic [XLEN-1:0] aluresult2;
  logic            pcsrc;
  logic            done;

  modport master (
    output instrucao, readdata1R, readdata2R, alusrc, alucontrol, branch,
    input  estado, opcode, rd, rs1, rs2, funct3, funct7, immediate, tipo,
           aluresult1, aluresult2, pcsrc, done
  );

  modport slave (
    input  instrucao, readdata1R, readdata2R, alusrc, alucontrol, branch,
    output estado, opcode, rd, rs1, rs2, funct3, funct7, immediate, tipo,
           aluresult1, aluresult2, pcsrc, done
  );
endinterface

// File: rtl/rv_decode_execute.sv
// Sequencing, decode and execute core of the multi-cycle RV32I subset
// datapath (lw, sw, sub, xor, addi, srl, beq).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : rv_decode_execute_if.slave. Inputs are the instruction, the
//          operands and the control bits. Outputs are the FSM state
//          (estado), the decoded fields, the ALU result and zero flag,
//          the branch decision and done.
// The decode fields are registered in ID and the ALU results in EX. Both
// sets hold their values until the same state comes round again.
module rv_decode_execute #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst,
  rv_decode_execute_if.slave bus
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EX    = 4'd2,
    S_MEM   = 4'd3,
    S_WB    = 4'd4,
    S_AUX1  = 4'd5,
    S_AUX2  = 4'd6,
    S_AUX3  = 4'd7,
    S_SUMPC = 4'd8,
    S_FIM   = 4'd9
  } state_t;

  state_t state, state_next;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_next;
  end

  always_comb begin
    state_next = S_FIM;
    case (state)
      S_IF:    state_next = S_ID;
      // An all-zero instruction marks the end of the program.
      S_ID:    state_next = (bus.instrucao != 32'd0) ? S_EX : S_FIM;
      S_EX:    state_next = S_AUX1;
      S_AUX1:  state_next = S_MEM;
      S_MEM:   state_next = S_WB;
      S_WB:    state_next = S_AUX2;
      S_AUX2:  state_next = S_AUX3;
      S_AUX3:  state_next = S_SUMPC;
      S_SUMPC: state_next = S_IF;
      S_FIM:   state_next = S_FIM;
      default: state_next = S_FIM;  // codes 10-15 fall into FIM
    endcase
  end

  // ---------------- decode ----------------
  logic [31:0] ins;
  logic [2:0]  d_tipo;
  logic [11:0] d_imm;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [6:0]  d_funct7;

  assign ins = bus.instrucao;

  always_comb begin
    d_tipo   = 3'd7;
    d_imm    = 12'd0;
    d_rd     = 5'd0;
    d_rs1    = 5'd0;
    d_rs2    = 5'd0;
    d_funct7 = 7'd0;
    case (ins[6:0])
      7'b0110011: begin
        d_tipo   = 3'd0;
        d_rd     = ins[11:7];
        d_rs1    = ins[19:15];
        d_rs2    = ins[24:20];
        d_funct7 = ins[31:25];
      end
      7'b0010011, 7'b0000011: begin
        d_tipo = (ins[6:0] == 7'b0010011) ? 3'd1 : 3'd2;
        d_imm  = ins[31:20];
        d_rd   = ins[11:7];
        d_rs1  = ins[19:15];
      end
      7'b0100011: begin
        d_tipo = 3'd3;
        d_imm  = {ins[31:25], ins[11:7]};
        d_rs1  = ins[19:15];
        d_rs2  = ins[24:20];
      end
      7'b1100011: begin
        // Branch offset is kept in halfwords; bit 0 of the byte offset is
        // always zero and is dropped.
        d_tipo = 3'd4;
        d_imm  = {ins[31], ins[7], ins[30:25], ins[11:8]};
        d_rs1  = ins[19:15];
        d_rs2  = ins[24:20];
      end
      default: ;
    endcase
  end

  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q, tipo_q;
  logic [11:0] imm_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [6:0]  funct7_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= '0;
      funct3_q <= '0;
      tipo_q   <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct7_q <= '0;
    end else if (state == S_ID) begin
      opcode_q <= ins[6:0];
      funct3_q <= ins[14:12];
      tipo_q   <= d_tipo;
      imm_q    <= d_imm;
      rd_q     <= d_rd;
      rs1_q    <= d_rs1;
      rs2_q    <= d_rs2;
      funct7_q <= d_funct7;
    end
  end

  // ---------------- execute ----------------
  logic [XLEN-1:0] op_a, op_b, alu;

  assign op_a = bus.readdata1R;
  // Operand B uses the immediate that was registered in ID.
  assign op_b = bus.alusrc ? {{(XLEN-12){imm_q[11]}}, imm_q} : bus.readdata2R;

  always_comb begin
    alu = '0;
    case (bus.alucontrol)
      4'b0010: alu = op_a + op_b;
      4'b0110: alu = op_a - op_b;
      4'b0011: alu = op_a ^ op_b;
      4'b0101: alu = op_a >> op_b[4:0];
      4'b0000: alu = op_a & op_b;
      4'b0001: alu = op_a | op_b;
      default: alu = '0;
    endcase
  end

  logic            zero_q, pcsrc_q;
  logic [XLEN-1:0] result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q   <= 1'b0;
      result_q <= '0;
      pcsrc_q  <= 1'b0;
    end else if (state == S_EX) begin
      zero_q   <= (alu == '0);
      result_q <= alu;
      pcsrc_q  <= bus.branch & (alu == '0);
    end
  end

  // ---------------- outputs ----------------
  assign bus.estado     = state;
  assign bus.opcode     = opcode_q;
  assign bus.rd         = rd_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.funct3     = funct3_q;
  assign bus.funct7     = funct7_q;
  assign bus.immediate  = imm_q;
  assign bus.tipo       = tipo_q;
  assign bus.aluresult1 = zero_q;
  assign bus.aluresult2 = result_q;
  assign bus.pcsrc      = pcsrc_q;
  assign bus.done       = (state == S_FIM);

endmodule

// File: tb/tb_rv_decode_execute.sv
// Bench for rv_decode_execute: directed cases followed by random instructions,
// all checked against a behavioural model of decode and ALU.
module tb_rv_decode_execute;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rv_decode_execute_if #(.XLEN(32)) bus ();

  rv_decode_execute #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  tipo;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
  } dec_t;

  // Expected order of states for one instruction, starting at IF.
  logic [3:0] exp_seq [0:8];

  // ---------------- reference model ----------------
  function automatic dec_t model_decode(input logic [31:0] i);
    dec_t d;
    logic [12:0] byte_off;
    d = '0;
    d.tipo = 3'd7;
    if (i[6:0] == 7'b0110011) begin
      d.tipo = 0; d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.f7 = i[31:25];
    end else if (i[6:0] == 7'b0010011 || i[6:0] == 7'b0000011) begin
      d.tipo = (i[6:0] == 7'b0010011) ? 3'd1 : 3'd2;
      d.imm = i[31:20]; d.rd = i[11:7]; d.rs1 = i[19:15];
    end else if (i[6:0] == 7'b0100011) begin
      d.tipo = 3; d.imm = {i[31:25], i[11:7]}; d.rs1 = i[19:15]; d.rs2 = i[24:20];
    end else if (i[6:0] == 7'b1100011) begin
      byte_off = {i[31], i[7], i[30:25], i[11:8], 1'b0};
      d.tipo = 4; d.imm = 12'(byte_off / 2); d.rs1 = i[19:15]; d.rs2 = i[24:20];
    end
    return d;
  endfunction

  function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctl);
    case (ctl)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0011: return a ^ b;
      4'b0101: return a >> (b % 32);
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string where);
    chk({where, ":estado"},     32'(bus.estado), 0);
    chk({where, ":opcode"},     32'(bus.opcode), 0);
    chk({where, ":rd"},         32'(bus.rd), 0);
    chk({where, ":rs1"},        32'(bus.rs1), 0);
    chk({where, ":rs2"},        32'(bus.rs2), 0);
    chk({where, ":funct3"},     32'(bus.funct3), 0);
    chk({where, ":funct7"},     32'(bus.funct7), 0);
    chk({where, ":immediate"},  32'(bus.immediate), 0);
    chk({where, ":tipo"},       32'(bus.tipo), 0);
    chk({where, ":aluresult1"}, 32'(bus.aluresult1), 0);
    chk({where, ":aluresult2"}, bus.aluresult2, 0);
    chk({where, ":pcsrc"},      32'(bus.pcsrc), 0);
    chk({where, ":done"},       32'(bus.done), 0);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with the core in IF. Runs one full instruction
  // and checks the state trail, the decode fields and the ALU result.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input logic asrc,
                           input logic [3:0] ctl, input logic br);
    dec_t        d;
    logic [31:0] bop, res;
    d   = model_decode(ins);
    bop = asrc ? 32'($signed(d.imm)) : b;
    res = model_alu(a, bop, ctl);
    bus.instrucao  = ins;
    bus.readdata1R = a;
    bus.readdata2R = b;
    bus.alusrc     = asrc;
    bus.alucontrol = ctl;
    bus.branch     = br;
    chk("estado_start", 32'(bus.estado), 32'(exp_seq[0]));
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("estado_step%0d", k), 32'(bus.estado), 32'(exp_seq[k % 9]));
      if (k == 2) begin
        chk("opcode", 32'(bus.opcode), 32'(ins[6:0]));
        chk("funct3", 32'(bus.funct3), 32'(ins[14:12]));
        chk("tipo",   32'(bus.tipo), 32'(d.tipo));
        chk("imm",    32'(bus.immediate), 32'(d.imm));
        chk("rd",     32'(bus.rd), 32'(d.rd));
        chk("rs1",    32'(bus.rs1), 32'(d.rs1));
        chk("rs2",    32'(bus.rs2), 32'(d.rs2));
        chk("funct7", 32'(bus.funct7), 32'(d.f7));
      end
      if (k == 3) begin
        chk("aluresult2", bus.aluresult2, res);
        chk("aluresult1", 32'(bus.aluresult1), 32'(res == 0));
        chk("pcsrc",      32'(bus.pcsrc), 32'(br && res == 0));
        chk("done_busy",  32'(bus.done), 0);
      end
    end
    chk("aluresult2_hold", bus.aluresult2, res);
    chk("tipo_hold",       32'(bus.tipo), 32'(d.tipo));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0]  ops [0:5];
    logic [3:0]  ctls [0:5];
    logic [31:0] r, a, b, last_res;
    logic [3:0]  ctl;

    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};
    ops  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    ctls = '{4'b0010, 4'b0110, 4'b0011, 4'b0101, 4'b0000, 4'b0001};

    bus.instrucao = 0; bus.readdata1R = 0; bus.readdata2R = 0;
    bus.alusrc = 0; bus.alucontrol = 0; bus.branch = 0;

    // Power-on reset.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Reset asserted mid-EX aborts the instruction at once.
    bus.instrucao = 32'h402081B3; bus.readdata1R = 10; bus.readdata2R = 3;
    bus.alucontrol = 4'b0110;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("mid_ex_estado", 32'(bus.estado), 2);
    chk("mid_ex_rd", 32'(bus.rd), 3);
    #1 rst = 1'b1;
    #1 chk_all_zero("mid_ex_reset");
    @(negedge clk);
    rst = 1'b0;

    // sub x3,x1,x2 : 10 - 3
    run_instr(32'h402081B3, 10, 3, 1'b0, 4'b0110, 1'b0);
    chk("sub_result", bus.aluresult2, 7);
    chk("sub_funct7", 32'(bus.funct7), 32'h20);
    // addi x5,x0,-1
    run_instr(32'hFFF00293, 0, 32'h1234, 1'b1, 4'b0010, 1'b0);
    chk("addi_imm", 32'(bus.immediate), 32'hFFF);
    chk("addi_result", bus.aluresult2, 32'hFFFFFFFF);
    // beq x1,x2,+8 taken, then not taken
    run_instr(32'h00208463, 5, 5, 1'b0, 4'b0110, 1'b1);
    chk("beq_imm", 32'(bus.immediate), 4);
    chk("beq_taken", 32'(bus.pcsrc), 1);
    run_instr(32'h00208463, 5, 6, 1'b0, 4'b0110, 1'b1);
    chk("beq_not_taken", 32'(bus.pcsrc), 0);
    // srl and xor
    run_instr(32'h0020D1B3, 32'h80000000, 31, 1'b0, 4'b0101, 1'b0);
    chk("srl_result", bus.aluresult2, 1);
    run_instr(32'h0020C1B3, 32'hF0F0, 32'h0FF0, 1'b0, 4'b0011, 1'b0);
    chk("xor_result", bus.aluresult2, 32'hFF00);
    // sw-style store and unused alucontrol code
    run_instr(32'hFE112E23, 32'h100, 7, 1'b1, 4'b1111, 1'b0);

    // Random instructions.
    for (int i = 0; i < 30; i++) begin
      r   = $urandom();
      a   = $urandom();
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
      ctl = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                        : ctls[$urandom_range(0, 5)];
      run_instr({r[31:7], ops[$urandom_range(0, 5)]}, a, b, 1'($urandom_range(0, 1)),
                ctl, 1'($urandom_range(0, 1)));
    end

    // Zero instruction ends the program: FIM is absorbing, outputs hold.
    last_res = bus.aluresult2;
    bus.instrucao = 32'd0;
    @(posedge clk); @(negedge clk);
    chk("fim_id", 32'(bus.estado), 1);
    @(posedge clk); @(negedge clk);
    chk("fim_enter", 32'(bus.estado), 9);
    chk("fim_done", 32'(bus.done), 1);
    chk("fim_tipo", 32'(bus.tipo), 7);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("fim_stay%0d", k), 32'(bus.estado), 9);
      chk($sformatf("fim_done%0d", k), 32'(bus.done), 1);
    end
    chk("fim_alu_hold", bus.aluresult2, last_res);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_decode_execute.md
Name: rv_decode_execute

Overview:
- Sequencing, decode and execute core of the multi-cycle RV32I subset datapath (lw, sw, sub, xor, addi, srl, beq).
- Owns the 10-state instruction-cycle FSM, splits the fetched instruction into fields and classifies it, and computes the ALU result and branch decision.
- Sits between the instruction fetch stage and the register file, control-signal generator and data memory. All of those consume its state output.

Parameters:
- XLEN, 32, datapath width. Instruction width is fixed at 32.

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  asynchronous, active-high reset
- instrucao  in  32  fetched instruction, stable from IF through SUMPC
- readdata1R  in  32  rs1 operand from register file
- readdata2R  in  32  rs2 operand from register file
- alusrc  in  1  1 = operand B is sign-extended immediate; 0 = readdata2R
- alucontrol  in  4  ALU operation select
- branch  in  1  current instruction is a branch
- estado  out  4  current FSM state
- opcode  out  7  instruction bits [6:0]
- rd, rs1, rs2  out  5 each  register indices
- funct3  out  3  instruction bits [14:12]
- funct7  out  7  instruction bits [31:25] for R-type, else 0
- immediate  out  12  decoded immediate
- tipo  out  3  instruction class
- aluresult1  out  1  zero flag (aluresult2 == 0)
- aluresult2  out  32  ALU result
- pcsrc  out  1  branch taken
- done  out  1  high while in FIM

Behaviour:
- Reset (async, rst=1):
  - estado = IF (0).
  - All other outputs = 0, including aluresult1=0 and done=0.
  - Reset asserted mid-instruction aborts it immediately.
- FSM encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, AUX1=5, AUX2=6, AUX3=7, SUMPC=8, FIM=9.
- FSM transitions, one per rising edge:
  - IF -> ID.
  - ID -> EX if instrucao != 0, else ID -> FIM.
  - EX -> AUX1 -> MEM -> WB -> AUX2 -> AUX3 -> SUMPC -> IF.
  - FIM is absorbing; done=1 in FIM. Illegal codes 10-15 go to FIM.
  - A normal instruction takes 9 cycles.
- Decode: registered on the rising edge while estado==ID; fields hold until the next ID.
  - tipo by opcode:
    - 0110011 -> 0 (R)
    - 0010011 -> 1 (I-arith)
    - 0000011 -> 2 (load)
    - 0100011 -> 3 (S)
    - 1100011 -> 4 (B)
    - any other opcode -> 7
  - immediate by class:
    - I/load: [31:20]
    - S: {[31:25],[11:7]}
    - B: {[31],[7],[30:25],[11:8]} (byte offset / 2)
    - R and unknown: 0
  - rd = [11:7] for R/I/load, 0 for S/B.
  - rs2 = [24:20] for R/S/B, 0 otherwise.
  - rs1 = [19:15] for all classes except unknown, which gets 0.
- Execute: registered on the rising edge while estado==EX; results hold until the next EX.
  - Operand A = readdata1R.
  - Operand B = alusrc ? sign_extend(immediate) : readdata2R. The immediate used is the already-registered decode value.
  - alucontrol operations:
    - 0010: add, modulo 2^32
    - 0110: sub (A−B), modulo 2^32
    - 0011: xor
    - 0101: srl, logical shift by B[4:0]
    - 0000: and
    - 0001: or
    - any other code: result 0
  - aluresult1 = (result == 0).
  - pcsrc = branch & (result == 0).
- Overflow is ignored and no flag is produced.
- FIM outputs hold their last values.

Test Plan:
- Reset, then sub: assert rst mid-EX -> estado=0 and all outputs 0 immediately. Release, then run 0x402081B3 (sub x3,x1,x2), readdata1R=10, readdata2R=3, alucontrol=0110, alusrc=0 -> tipo=0, rd=3, rs1=1, rs2=2, funct7=0x20; after EX aluresult2=7, aluresult1=0.
- addi with negative immediate: 0xFFF00293 (addi x5,x0,-1), alusrc=1, alucontrol=0010, readdata1R=0 -> tipo=1, immediate=0xFFF, aluresult2=0xFFFFFFFF.
- Taken branch: 0x00208463 (beq x1,x2,+8), readdata1R=readdata2R=5, alucontrol=0110, branch=1 -> tipo=4, immediate=4, aluresult1=1, pcsrc=1. Repeat with readdata2R=6 -> pcsrc=0.
- Logical shift and xor: srl with readdata1R=0x80000000, B=31 -> aluresult2=1. xor 0xF0F0 ^ 0x0FF0 -> 0xFF00.
- Sequencing: nonzero instruction -> estado visits 0,1,2,5,3,4,6,7,8,0. instrucao=0 at ID -> estado=9, done=1, and it stays in 9 for 5 further cycles.
